// File: rtl/plic_lite_if.sv
// plic_lite_if: interrupt request, core handshake and 64-bit bus signals for plic_lite.
interface plic_lite_if #(parameter int NUM_SRC = 4);
    logic [NUM_SRC-1:0] irq_src;
    logic [3:0]         interrupt_vector;
    logic               interrupt_ack;
    logic [63:0]        bus_address;
    logic [63:0]        bus_write_data;
    logic               bus_write_enable;
    logic               bus_read_enable;
    logic [63:0]        bus_read_data;
    modport master (
        output irq_src, interrupt_ack, bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        input  interrupt_vector, bus_read_data
    );
    modport slave (
        input  irq_src, interrupt_ack, bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        output interrupt_vector, bus_read_data
    );
endinterface

// File: rtl/plic_lite.sv
// plic_lite: edge-triggered interrupt controller with fixed priority and claim/complete handshake.
module plic_lite #(
    parameter int          NUM_SRC   = 4,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0C00_0000
) (
    input logic        clk,
    input logic        reset,
    plic_lite_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
    state_t             state_q;
    logic [NUM_SRC-1:0] src_q, pend_q, pend_d, en_q, cur_mask, rise;
    logic [3:0]         cur_q, vec_q, sel;
    logic [63:0]        rdata_q, rd_val, claimed;
    logic [4:0]         off;
    logic               hit, wr_en, wr_cmp, ack_ok, dis_cur, cmp_ok;
    assign off      = bus.bus_address[4:0];
    assign hit      = bus.bus_address[63:5] == BASE_ADDR[63:5];
    assign wr_en    = bus.bus_write_enable && hit && off == 5'h08;
    assign wr_cmp   = bus.bus_write_enable && hit && off == 5'h18;
    assign rise     = bus.irq_src & ~src_q;
    assign cur_mask = NUM_SRC'(1) << (cur_q - 4'd1);
    assign ack_ok   = state_q == PRESENT && bus.interrupt_ack;
    assign dis_cur  = wr_en && (cur_mask & bus.bus_write_data[NUM_SRC-1:0]) == '0;
    assign cmp_ok   = state_q == SERVICE && wr_cmp && bus.bus_write_data[3:0] == cur_q;
    // a new edge in the ack cycle must survive the clear
    assign pend_d   = (pend_q & ~(ack_ok ? cur_mask : '0)) | rise;
    assign claimed  = state_q == SERVICE ? 64'(cur_q) : 64'd0;
    always_comb begin
        sel = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pend_q[i] && en_q[i]) sel = 4'(i + 1);
    end
    always_comb begin
        rd_val = !hit         ? 64'd0 :
                 off == 5'h00 ? 64'(pend_q) :
                 off == 5'h08 ? 64'(en_q) :
                 off == 5'h10 ? claimed : 64'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            cur_q   <= 4'd0;
            vec_q   <= 4'd0;
            rdata_q <= 64'd0;
        end else begin
            src_q  <= bus.irq_src;
            pend_q <= pend_d;
            if (wr_en) en_q <= bus.bus_write_data[NUM_SRC-1:0];
            if (bus.bus_read_enable) rdata_q <= rd_val;
            unique case (state_q)
                IDLE: if (sel != 4'd0) begin
                    state_q <= PRESENT;
                    cur_q   <= sel;
                    vec_q   <= sel;
                end
                PRESENT: if (ack_ok) begin
                    state_q <= SERVICE;
                    vec_q   <= 4'd0;
                end else if (dis_cur) begin
                    state_q <= IDLE;
                    cur_q   <= 4'd0;
                    vec_q   <= 4'd0;
                end
                SERVICE: if (cmp_ok) begin
                    state_q <= IDLE;
                    cur_q   <= 4'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.interrupt_vector = vec_q;
    assign bus.bus_read_data    = rdata_q;
endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: directed checks of plic_lite priority, handshake, bus map and reset.
module tb_plic_lite;
    localparam logic [63:0] BASE = 64'h0000_0000_0C00_0000;
    localparam logic [63:0] A_PEND = BASE, A_EN = BASE + 64'h08, A_CLM = BASE + 64'h10, A_CMP = BASE + 64'h18;
    logic clk = 1'b0, reset = 1'b1;
    int   n_tests = 0, n_fail = 0;
    logic [63:0] d;
    plic_lite_if #(.NUM_SRC(4)) bus ();
    plic_lite #(.NUM_SRC(4), .BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [63:0] a, input logic [63:0] v);
        bus.bus_address = a;
        bus.bus_write_data = v;
        bus.bus_write_enable = 1'b1;
        tick();
        bus.bus_write_enable = 1'b0;
    endtask
    task automatic rd(input logic [63:0] a, output logic [63:0] v);
        bus.bus_address = a;
        bus.bus_read_enable = 1'b1;
        tick();
        bus.bus_read_enable = 1'b0;
        v = bus.bus_read_data;
    endtask
    task automatic ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask
    initial begin
        bus.irq_src = '0;
        bus.interrupt_ack = 1'b0;
        bus.bus_address = '0;
        bus.bus_write_data = '0;
        bus.bus_write_enable = 1'b0;
        bus.bus_read_enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_vec", 64'(bus.interrupt_vector), 64'd0);
        check("rst_rdata", bus.bus_read_data, 64'd0);
        // basic flow
        wr(A_EN, 64'h1);
        bus.irq_src = 4'b0001;
        tick();
        bus.irq_src = 4'b0000;
        check("lat_e0", 64'(bus.interrupt_vector), 64'd0);
        tick();
        check("lat_e1", 64'(bus.interrupt_vector), 64'd1);
        rd(A_PEND, d);
        check("pend_before_ack", d, 64'h1);
        ack();
        check("ack_vec", 64'(bus.interrupt_vector), 64'd0);
        rd(A_CLM, d);
        check("claimed1", d, 64'd1);
        rd(A_PEND, d);
        check("pend_after_ack", d, 64'h0);
        wr(A_CMP, 64'd1);
        rd(A_CLM, d);
        check("claimed_after_cmp", d, 64'd0);
        check("idle_vec", 64'(bus.interrupt_vector), 64'd0);
        // priority and stability
        wr(A_EN, 64'hF);
        bus.irq_src = 4'b0100;
        tick();
        tick();
        check("prio_vec3", 64'(bus.interrupt_vector), 64'd3);
        bus.irq_src = 4'b0101;
        tick();
        tick();
        check("stable_vec3", 64'(bus.interrupt_vector), 64'd3);
        ack();
        check("ack3_vec", 64'(bus.interrupt_vector), 64'd0);
        rd(A_CLM, d);
        check("claimed3", d, 64'd3);
        wr(A_CMP, 64'd3);
        check("cmp3_c", 64'(bus.interrupt_vector), 64'd0);
        tick();
        check("cmp3_c1_vec1", 64'(bus.interrupt_vector), 64'd1);
        ack();
        wr(A_CMP, 64'd1);
        bus.irq_src = 4'b0000;
        tick();
        check("none_pending", 64'(bus.interrupt_vector), 64'd0);
        // disable while presenting
        bus.irq_src = 4'b0010;
        tick();
        bus.irq_src = 4'b0000;
        tick();
        check("present2", 64'(bus.interrupt_vector), 64'd2);
        wr(A_EN, 64'h0);
        check("disable_vec", 64'(bus.interrupt_vector), 64'd0);
        rd(A_PEND, d);
        check("disable_pend_kept", d, 64'h2);
        wr(A_EN, 64'h2);
        check("reen_w", 64'(bus.interrupt_vector), 64'd0);
        tick();
        check("reen_vec2", 64'(bus.interrupt_vector), 64'd2);
        // rising edge in the ack cycle, then mismatched complete
        bus.irq_src = 4'b0010;
        ack();
        bus.irq_src = 4'b0000;
        check("ack_edge_vec", 64'(bus.interrupt_vector), 64'd0);
        wr(A_CMP, 64'd5);
        rd(A_CLM, d);
        check("bad_cmp_claimed", d, 64'd2);
        rd(A_PEND, d);
        check("ack_edge_pend", d, 64'h2);
        check("bad_cmp_vec", 64'(bus.interrupt_vector), 64'd0);
        wr(A_CMP, 64'd2);
        tick();
        check("represent2", 64'(bus.interrupt_vector), 64'd2);
        // reset during PRESENT
        reset = 1'b1;
        tick();
        check("midrst_vec", 64'(bus.interrupt_vector), 64'd0);
        reset = 1'b0;
        rd(A_PEND, d);
        check("midrst_pend", d, 64'h0);
        rd(A_EN, d);
        check("midrst_en", d, 64'h0);
        rd(A_CLM, d);
        check("midrst_clm", d, 64'h0);
        // bus map
        wr(A_EN, 64'hFFFF);
        rd(A_EN, d);
        check("en_mask", d, 64'hF);
        rd(64'h1000, d);
        check("unmapped_rd", d, 64'h0);
        wr(BASE + 64'h28, 64'h0);
        rd(A_EN, d);
        check("unmapped_wr", d, 64'hF);
        wr(A_PEND, 64'hF);
        rd(A_PEND, d);
        check("ro_pend_wr", d, 64'h0);
        rd(A_CMP, d);
        check("cmp_rd_zero", d, 64'h0);
        check("final_vec", 64'(bus.interrupt_vector), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
